// File: rtl/ab_sched.sv
// ab_sched: round-robin scheduler sharing one a/b/y datapath unit between two requesters
module ab_sched #(
   parameter int HOLD_W = 4,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              res,
   input  logic              req0,
   input  logic [1:0]        ab0,
   input  logic [HOLD_W-1:0] hold0,
   input  logic              req1,
   input  logic [1:0]        ab1,
   input  logic [HOLD_W-1:0] hold1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              a,
   output logic              b,
   input  logic              y,
   output logic              rsp_valid,
   output logic              rsp_id,
   output logic              rsp_y,
   output logic              busy,
   output logic [CNT_W-1:0]  cnt0,
   output logic [CNT_W-1:0]  cnt1
);
   typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;
   state_t            state;
   logic              last;
   logic              id;
   logic [HOLD_W-1:0] left;
   logic              win;
   logic              take;
   logic [1:0]        sel_ab;
   logic [HOLD_W-1:0] sel_hold;
   logic [HOLD_W-1:0] sel_len;
   // arbitration: lone requester wins, ties go to the one not served last; grants only in IDLE
   always_comb begin
      win      = (req0 & req1) ? ~last : req1;
      take     = ~res & (state == IDLE) & (req0 | req1);
      gnt0     = take & ~win;
      gnt1     = take & win;
      sel_ab   = win ? ab1 : ab0;
      sel_hold = win ? hold1 : hold0;
      sel_len  = (sel_hold == '0) ? {{(HOLD_W-1){1'b0}}, 1'b1} : sel_hold;
   end
   assign busy = (state != IDLE);
   // job sequencing: latch on grant, drive a/b for N cycles, capture y, report and count
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state     <= IDLE;
         last      <= 1'b1;
         id        <= 1'b0;
         left      <= '0;
         a         <= 1'b0;
         b         <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_y     <= 1'b0;
         cnt0      <= '0;
         cnt1      <= '0;
      end else begin
         case (state)
            IDLE: if (take) begin
               state  <= DRIVE;
               last   <= win;
               id     <= win;
               {a, b} <= sel_ab;
               left   <= sel_len;
            end
            DRIVE: if (left == {{(HOLD_W-1){1'b0}}, 1'b1}) begin
               state     <= RESP;
               {a, b}    <= 2'b00;
               rsp_valid <= 1'b1;
               rsp_id    <= id;
               rsp_y     <= y;
            end else begin
               left <= left - 1'b1;
            end
            RESP: begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
               cnt0      <= id ? cnt0 : cnt0 + 1'b1;
               cnt1      <= id ? cnt1 + 1'b1 : cnt1;
            end
            default: state <= IDLE;
         endcase
      end
   end
   // the two grants are mutually exclusive by construction
   always_ff @(posedge clk) begin
      if (!res) assert (!(gnt0 && gnt1));
   end
endmodule

// File: tb/tb_ab_sched.sv
// tb_ab_sched: vector table, directed corner sequences and a random run against a job-timeline model
module tb_ab_sched;
   logic       clk, res;
   logic       req0, req1, y;
   logic [1:0] ab0, ab1;
   logic [3:0] hold0, hold1;
   logic       gnt0, gnt1, a, b, rsp_valid, rsp_id, rsp_y, busy;
   logic [7:0] cnt0, cnt1;

   ab_sched #(.HOLD_W(4), .CNT_W(8)) dut (
      .clk(clk), .res(res), .req0(req0), .ab0(ab0), .hold0(hold0),
      .req1(req1), .ab1(ab1), .hold1(hold1), .gnt0(gnt0), .gnt1(gnt1),
      .a(a), .b(b), .y(y), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
      .rsp_y(rsp_y), .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;
   int c = 0;

   // reference model: one job described by its grant cycle, length, stimulus and owner
   logic       m_act, m_last, m_jid, m_ys, m_id, m_y;
   int         m_jt, m_jn;
   logic [1:0] m_ab;
   logic [7:0] m_cnt0, m_cnt1;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, c);
      end
   endtask

   task automatic model_reset();
      m_act = 0; m_last = 1; m_jid = 0; m_ys = 0; m_id = 0; m_y = 0;
      m_jt = 0; m_jn = 1; m_ab = 0; m_cnt0 = 0; m_cnt1 = 0;
   endtask

   // called at a falling edge: check this cycle against the model, advance it, move past the next rising edge
   task automatic tick();
      logic eg0, eg1, ea, eb, ebusy, erv, w, done;
      int rel;
      eg0 = 0; eg1 = 0; ea = 0; eb = 0; ebusy = 0; erv = 0; done = 0; rel = 0;
      w = (req0 && req1) ? !m_last : req1;
      if (m_act) begin
         rel = c - m_jt;
         ebusy = (rel >= 1) && (rel <= m_jn + 1);
         if (rel >= 1 && rel <= m_jn) {ea, eb} = m_ab;
         if (rel == m_jn) m_ys = y;
         if (rel == m_jn + 1) begin
            erv = 1; m_id = m_jid; m_y = m_ys; done = 1;
         end
      end else if (req0 || req1) begin
         eg0 = !w; eg1 = w;
      end
      chk("gnt0", int'(gnt0), int'(eg0));
      chk("gnt1", int'(gnt1), int'(eg1));
      chk("a", int'(a), int'(ea));
      chk("b", int'(b), int'(eb));
      chk("busy", int'(busy), int'(ebusy));
      chk("rsp_valid", int'(rsp_valid), int'(erv));
      chk("rsp_id", int'(rsp_id), int'(m_id));
      chk("rsp_y", int'(rsp_y), int'(m_y));
      chk("cnt0", int'(cnt0), int'(m_cnt0));
      chk("cnt1", int'(cnt1), int'(m_cnt1));
      if (done) begin
         if (m_jid) m_cnt1 = m_cnt1 + 8'd1; else m_cnt0 = m_cnt0 + 8'd1;
         m_act = 0;
      end
      if (eg0 || eg1) begin
         m_act = 1; m_jt = c; m_jid = w; m_last = w;
         m_ab = w ? ab1 : ab0;
         m_jn = (w ? hold1 : hold0) == 0 ? 1 : int'(w ? hold1 : hold0);
      end
      @(posedge clk);
      #1;
      c++;
   endtask

   task automatic cyc();
      @(negedge clk);
      tick();
   endtask

   task automatic do_reset();
      res = 1; req0 = 0; req1 = 0; y = 0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_gnt", int'({gnt0, gnt1}), 0);
      chk("rst_ab", int'({a, b}), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_rsp", int'({rsp_valid, rsp_id, rsp_y}), 0);
      chk("rst_cnt", int'({cnt0, cnt1}), 0);
      res = 0;
      model_reset();
   endtask

   typedef struct {
      logic       r0;
      logic [1:0] a0;
      logic [3:0] h0;
      logic       r1;
      logic [1:0] a1;
      logic [3:0] h1;
      logic       yi;
      logic       g0, g1, ea, eb, bsy, rv, rid, ry;
      logic [7:0] c0, c1;
   } vec_t;

   vec_t tv[10];

   initial begin
      int tg0, tg1, ng, lastg, nrv;
      logic seen1;
      tv[0] = '{1'b1, 2'b10, 4'd3, 1'b0, 2'b00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
      tv[1] = '{1'b0, 2'b01, 4'd7, 1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
      tv[2] = '{1'b0, 2'b00, 4'd0, 1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
      tv[3] = '{1'b0, 2'b00, 4'd0, 1'b0, 2'b00, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
      tv[4] = '{1'b0, 2'b00, 4'd0, 1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0, 8'd0};
      tv[5] = '{1'b0, 2'b00, 4'd0, 1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 8'd0};
      tv[6] = '{1'b0, 2'b00, 4'd0, 1'b1, 2'b11, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 8'd0};
      tv[7] = '{1'b0, 2'b00, 4'd0, 1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1, 8'd0};
      tv[8] = '{1'b0, 2'b00, 4'd0, 1'b0, 2'b00, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 8'd0};
      tv[9] = '{1'b0, 2'b00, 4'd0, 1'b0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 8'd1};
      res = 1; req0 = 0; req1 = 0; ab0 = 0; ab1 = 0; hold0 = 0; hold1 = 0; y = 0;
      model_reset();
      do_reset();

      // single job on requester 0, then a zero-hold job on requester 1
      for (int i = 0; i < 10; i++) begin
         req0 = tv[i].r0; ab0 = tv[i].a0; hold0 = tv[i].h0;
         req1 = tv[i].r1; ab1 = tv[i].a1; hold1 = tv[i].h1; y = tv[i].yi;
         @(negedge clk);
         chk($sformatf("v%0d_gnt", i), int'({gnt0, gnt1}), int'({tv[i].g0, tv[i].g1}));
         chk($sformatf("v%0d_ab", i), int'({a, b}), int'({tv[i].ea, tv[i].eb}));
         chk($sformatf("v%0d_busy", i), int'(busy), int'(tv[i].bsy));
         chk($sformatf("v%0d_rsp", i), int'({rsp_valid, rsp_id, rsp_y}), int'({tv[i].rv, tv[i].rid, tv[i].ry}));
         chk($sformatf("v%0d_cnt", i), int'({cnt0, cnt1}), int'({tv[i].c0, tv[i].c1}));
         tick();
      end

      // late request: req1 rises while requester 0 drives
      tg0 = -100; tg1 = -1; seen1 = 0;
      for (int i = 0; i < 20; i++) begin
         req0 = (i == 0); ab0 = 2'b01; hold0 = 4'd4; y = 1'($urandom);
         if (i == 2) begin req1 = 1; ab1 = 2'b10; hold1 = 4'd2; end
         if (seen1) req1 = 0;
         @(negedge clk);
         if (gnt0) tg0 = c;
         if (gnt1) begin tg1 = c; seen1 = 1; end
         if (i >= 1 && i <= 4) chk("late_ab", int'({a, b}), 1);
         tick();
      end
      chk("late_gap", tg1 - tg0, 6);

      // tie arbitration from reset: grants must alternate 0,1,0,1
      do_reset();
      ng = 0; hold0 = 4'd2; hold1 = 4'd2; ab0 = 2'b10; ab1 = 2'b01;
      for (int i = 0; i < 40; i++) begin
         req0 = (ng < 4); req1 = (ng < 4); y = 1'($urandom);
         @(negedge clk);
         if (gnt0 || gnt1) begin
            chk("tie_order", int'(gnt1), ng % 2);
            ng++;
         end
         if (rsp_valid) chk("tie_rsp_id", int'(rsp_id), (ng - 1) % 2);
         tick();
      end
      chk("tie_jobs", ng, 4);
      chk("tie_cnt0", int'(cnt0), 2);
      chk("tie_cnt1", int'(cnt1), 2);

      // counter wrap: 256 back-to-back one-cycle jobs on requester 0
      do_reset();
      ng = 0; lastg = 0; hold0 = 4'd1;
      for (int i = 0; i < 900 && ng < 256; i++) begin
         req0 = 1; ab0 = 2'($urandom); y = 1'($urandom);
         @(negedge clk);
         if (gnt0) begin
            if (ng > 0) chk("wrap_spacing", c - lastg, 3);
            lastg = c; ng++;
         end
         tick();
      end
      req0 = 0;
      for (int i = 0; i < 4; i++) cyc();
      chk("wrap_jobs", ng, 256);
      chk("wrap_cnt0", int'(cnt0), 0);
      chk("wrap_cnt1", int'(cnt1), 0);

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         req0 = ($urandom_range(0, 3) != 0); req1 = ($urandom_range(0, 2) != 0);
         ab0 = 2'($urandom); ab1 = 2'($urandom);
         hold0 = 4'($urandom_range(0, 5)); hold1 = 4'($urandom_range(0, 5));
         y = 1'($urandom);
         cyc();
      end

      // asynchronous reset in the middle of a drive phase
      do_reset();
      req0 = 1; ab0 = 2'b11; hold0 = 4'd5;
      cyc();
      req0 = 0;
      cyc();
      cyc();
      chk("pre_abort_ab", int'({a, b}), 3);
      #2;
      res = 1;
      #1;
      chk("abort_ab", int'({a, b}), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_rsp", int'(rsp_valid), 0);
      @(posedge clk);
      #1;
      res = 0;
      model_reset();
      nrv = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (rsp_valid) nrv++;
         tick();
      end
      chk("abort_no_rsp", nrv, 0);
      chk("abort_cnt0", int'(cnt0), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
